// File: rtl/si_pkg.sv
// Shared definitions for the serial-interface PISO shifter: word ordering
// and the elaboration-time geometry helpers.
package si_pkg;

  typedef enum logic {
    ORDER_LSB = 1'b0,
    ORDER_MSB = 1'b1
  } order_e;

  function automatic int calc_beats(input int ssize, input int lanes);
    return ssize / lanes;
  endfunction

  // A one-beat word still needs a 1-bit counter.
  function automatic int calc_cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  function automatic bit lanes_legal(input int ssize, input int lanes);
    return (lanes == 1 || lanes == 2 || lanes == 4 || lanes == 8) &&
           (ssize > 0) && (ssize % lanes == 0);
  endfunction

endpackage

// File: rtl/si_hold_buf.sv
// One-entry valid/ready holding register for a parallel word and its
// ordering flag; ready depends only on the registered full flag.
module si_hold_buf
  import si_pkg::*;
#(
  parameter int SSIZE = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             push_valid,
  input  logic [SSIZE-1:0] push_data,
  input  order_e           push_order,
  input  logic             pop,
  output logic             ready,
  output logic             full,
  output logic [SSIZE-1:0] hold_data,
  output order_e           hold_order
);

  logic             full_q, full_d;
  logic [SSIZE-1:0] data_q, data_d;
  order_e           order_q, order_d;

  always_comb begin
    full_d  = full_q;
    data_d  = data_q;
    order_d = order_q;
    // pop only happens while full and push only while empty, so they never collide
    if (pop) begin
      full_d = 1'b0;
    end
    if (push_valid && !full_q) begin
      full_d  = 1'b1;
      data_d  = push_data;
      order_d = push_order;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      full_q  <= 1'b0;
      data_q  <= '0;
      order_q <= ORDER_LSB;
    end else begin
      full_q  <= full_d;
      data_q  <= data_d;
      order_q <= order_d;
    end
  end

  assign ready      = !full_q;
  assign full       = full_q;
  assign hold_data  = data_q;
  assign hold_order = order_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter: holding buffer feeds a LANES-wide shift
// register with per-word bit ordering, beat counter and end-of-word pulse.
module piso_serializer
  import si_pkg::*;
#(
  parameter int SSIZE = 16,
  parameter int LANES = 1
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [SSIZE-1:0] in_data,
  input  logic             in_msb_first,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sh_en,
  output logic [LANES-1:0] sr_out,
  output logic             sr_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int BEATS = calc_beats(SSIZE, LANES);
  localparam int CNT_W = calc_cnt_w(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if (!lanes_legal(SSIZE, LANES)) begin : g_bad_lanes
    $error("piso_serializer: SSIZE must be a positive multiple of LANES (1, 2, 4 or 8)");
  end

  logic             hold_full;
  logic [SSIZE-1:0] hold_data;
  order_e           hold_order;
  logic             pop;
  logic             last_beat;

  logic [SSIZE-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             active_q, active_d;
  order_e           order_q, order_d;
  logic             word_done_q, word_done_d;

  si_hold_buf #(.SSIZE(SSIZE)) u_hold (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .push_valid (in_valid),
    .push_data  (in_data),
    .push_order (order_e'(in_msb_first)),
    .pop        (pop),
    .ready      (in_ready),
    .full       (hold_full),
    .hold_data  (hold_data),
    .hold_order (hold_order)
  );

  assign last_beat = active_q && sh_en && (beat_cnt_q == LAST_BEAT);
  // Reload on the final beat keeps back-to-back words gapless.
  assign pop = hold_full && (!active_q || last_beat);

  always_comb begin
    sr_d        = sr_q;
    beat_cnt_d  = beat_cnt_q;
    active_d    = active_q;
    order_d     = order_q;
    word_done_d = last_beat;
    if (pop) begin
      sr_d       = hold_data;
      order_d    = hold_order;
      beat_cnt_d = '0;
      active_d   = 1'b1;
    end else if (last_beat) begin
      sr_d       = '0;
      beat_cnt_d = '0;
      active_d   = 1'b0;
    end else if (active_q && sh_en) begin
      sr_d       = (order_q == ORDER_MSB) ? (sr_q << LANES) : (sr_q >> LANES);
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      sr_q        <= '0;
      beat_cnt_q  <= '0;
      active_q    <= 1'b0;
      order_q     <= ORDER_LSB;
      word_done_q <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      beat_cnt_q  <= beat_cnt_d;
      active_q    <= active_d;
      order_q     <= order_d;
      word_done_q <= word_done_d;
    end
  end

  always_comb begin
    sr_out = '0;
    if (active_q) begin
      sr_out = (order_q == ORDER_MSB) ? sr_q[SSIZE-1 -: LANES] : sr_q[LANES-1:0];
    end
  end

  assign sr_valid  = active_q;
  assign word_done = word_done_q;
  assign busy      = active_q || hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: a LANES=1 and a LANES=4 instance checked every
// cycle against a word/beat-index reference model, plus directed sequences.
module tb_piso_serializer;

  logic        rclk = 1'b0;
  logic        rrst_n;
  logic        in_valid [2];
  logic        in_msb   [2];
  logic        sh_en    [2];
  logic [15:0] in_data  [2];
  logic        in_ready [2];
  logic        sr_valid [2];
  logic        word_done[2];
  logic        busy     [2];
  logic [0:0]  sr_out1;
  logic [3:0]  sr_out4;

  int errors = 0;
  int checks = 0;

  always #5 rclk = ~rclk;

  piso_serializer #(.SSIZE(16), .LANES(1)) u_dut1 (
    .rclk(rclk), .rrst_n(rrst_n), .in_data(in_data[0]), .in_msb_first(in_msb[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .sh_en(sh_en[0]), .sr_out(sr_out1),
    .sr_valid(sr_valid[0]), .word_done(word_done[0]), .busy(busy[0])
  );

  piso_serializer #(.SSIZE(16), .LANES(4)) u_dut4 (
    .rclk(rclk), .rrst_n(rrst_n), .in_data(in_data[1]), .in_msb_first(in_msb[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .sh_en(sh_en[1]), .sr_out(sr_out4),
    .sr_valid(sr_valid[1]), .word_done(word_done[1]), .busy(busy[1])
  );

  // reference model: current word + beat index, one pending word
  bit          m_hfull [2];
  logic [15:0] m_hword [2];
  bit          m_hmsb  [2];
  bit          m_act   [2];
  logic [15:0] m_word  [2];
  bit          m_msb   [2];
  int          m_beat  [2];
  bit          m_done  [2];
  bit          m_acc   [2];
  int          m_shifts[2];

  function automatic int lanes_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic logic [3:0] model_out(input int k);
    int l;
    int pos;
    logic [15:0] w;
    if (!m_act[k]) return 4'h0;
    l   = lanes_of(k);
    pos = m_msb[k] ? (16 - (m_beat[k] + 1) * l) : (m_beat[k] * l);
    w   = m_word[k] >> pos;
    return w[3:0] & 4'((1 << l) - 1);
  endfunction

  function automatic logic [3:0] dut_out(input int k);
    return (k == 0) ? {3'b000, sr_out1} : sr_out4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_hfull[k] = 0; m_hword[k] = '0; m_hmsb[k] = 0; m_act[k] = 0;
      m_word[k] = '0; m_msb[k] = 0; m_beat[k] = 0; m_done[k] = 0; m_acc[k] = 0;
    end
  endtask

  task automatic model_edge(input int k);
    int nb;
    bit last, acc, pop;
    nb   = 16 / lanes_of(k);
    last = m_act[k] && sh_en[k] && (m_beat[k] == nb - 1);
    acc  = in_valid[k] && !m_hfull[k];
    pop  = m_hfull[k] && (!m_act[k] || last);
    if (m_act[k] && sh_en[k]) m_shifts[k]++;
    m_done[k] = last;
    m_acc[k]  = acc;
    if (pop) begin
      m_act[k] = 1; m_word[k] = m_hword[k]; m_msb[k] = m_hmsb[k]; m_beat[k] = 0;
      m_hfull[k] = 0;
    end else if (last) begin
      m_act[k] = 0; m_beat[k] = 0;
    end else if (m_act[k] && sh_en[k]) begin
      m_beat[k]++;
    end
    if (acc) begin
      m_hfull[k] = 1; m_hword[k] = in_data[k]; m_hmsb[k] = in_msb[k];
    end
  endtask

  task automatic check_model(input int k);
    chk($sformatf("in_ready%0d", k), in_ready[k], !m_hfull[k]);
    chk($sformatf("sr_valid%0d", k), sr_valid[k], m_act[k]);
    chk($sformatf("busy%0d", k), busy[k], m_act[k] || m_hfull[k]);
    chk($sformatf("word_done%0d", k), word_done[k], m_done[k]);
    chk($sformatf("sr_out%0d", k), dut_out(k), model_out(k));
  endtask

  task automatic tick();
    @(posedge rclk);
    for (int k = 0; k < 2; k++) begin
      if (!rrst_n) model_reset();
      else model_edge(k);
    end
    #1;
    for (int k = 0; k < 2; k++) check_model(k);
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_sr_valid"}, sr_valid[k], 0);
      chk({tag, "_sr_out"}, dut_out(k), 0);
      chk({tag, "_in_ready"}, in_ready[k], 1);
      chk({tag, "_busy"}, busy[k], 0);
      chk({tag, "_word_done"}, word_done[k], 0);
    end
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 0; in_msb[k] = 0; sh_en[k] = 0; in_data[k] = '0;
    end
  endtask

  task automatic offer(input int k, input logic [15:0] d, input bit msb, input int budget);
    bit got;
    got = 0;
    in_valid[k] = 1; in_data[k] = d; in_msb[k] = msb;
    for (int c = 0; c < budget && !got; c++) begin
      tick();
      got = m_acc[k];
    end
    in_valid[k] = 0;
    chk($sformatf("accept%0d_%h", k, d), got, 1);
  endtask

  typedef struct {
    int          k;
    logic [15:0] data;
    bit          msb;
    logic [15:0] exp_seq;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] stream;
    logic [15:0] words[3];
    logic [15:0] seq;
    int n, vcyc, dones, first, runs;
    int done_at[$];
    bit prev_v;

    vecs[0] = '{k: 0, data: 16'hA5C3, msb: 0, exp_seq: 16'hC3A5};
    vecs[1] = '{k: 0, data: 16'hA5C3, msb: 1, exp_seq: 16'hA5C3};
    vecs[2] = '{k: 1, data: 16'h1234, msb: 0, exp_seq: 16'h4321};
    vecs[3] = '{k: 1, data: 16'h1234, msb: 1, exp_seq: 16'h1234};

    idle_inputs();
    rrst_n = 1'b0;
    model_reset();
    m_shifts[0] = 0; m_shifts[1] = 0;
    #12;
    chk_reset_outputs("reset");
    rrst_n = 1'b1;
    tick();

    // table-driven single words
    for (int i = 0; i < 4; i++) begin
      int k, l;
      k = vecs[i].k;
      l = lanes_of(k);
      offer(k, vecs[i].data, vecs[i].msb, 4);
      sh_en[k] = 1;
      seq = '0; vcyc = 0; dones = 0;
      for (int c = 0; c < 24; c++) begin
        if (sr_valid[k]) begin
          seq = (seq << l) | 16'(dut_out(k));
          vcyc++;
        end
        tick();
        if (word_done[k]) dones++;
      end
      sh_en[k] = 0;
      chk($sformatf("vec%0d_seq", i), seq, vecs[i].exp_seq);
      chk($sformatf("vec%0d_beats", i), vcyc, 16 / l);
      chk($sformatf("vec%0d_done", i), dones, 1);
    end

    // back-to-back words without a gap in sr_valid
    in_valid[0] = 1; in_data[0] = 16'hFFFF; in_msb[0] = 0; sh_en[0] = 1;
    n = 0; vcyc = 0; first = -1; runs = 0; prev_v = 0;
    done_at.delete();
    for (int c = 0; c < 45; c++) begin
      tick();
      if (m_acc[0]) begin
        if (n == 0) in_data[0] = 16'h0000;
        else in_valid[0] = 0;
        n++;
      end
      if (sr_valid[0]) begin
        vcyc++;
        if (!prev_v) runs++;
        if (first < 0) first = c;
      end
      prev_v = sr_valid[0];
      if (word_done[0]) done_at.push_back(c - first);
    end
    sh_en[0] = 0; in_valid[0] = 0;
    chk("b2b_valid_cycles", vcyc, 32);
    chk("b2b_valid_runs", runs, 1);
    chk("b2b_done_count", done_at.size(), 2);
    if (done_at.size() == 2) begin
      chk("b2b_done0_pos", done_at[0], 16);
      chk("b2b_done1_pos", done_at[1], 32);
    end

    // backpressure: two words held, third waits, then drain in order
    words[0] = 16'h0001; words[1] = 16'hBEEF; words[2] = 16'h5A0F;
    offer(0, words[0], 0, 4);
    offer(0, words[1], 0, 4);
    in_valid[0] = 1; in_data[0] = words[2]; in_msb[0] = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_in_ready_low", in_ready[0], 0);
      chk("bp_sr_out_w1b0", sr_out1, 1);
      chk("bp_sr_valid", sr_valid[0], 1);
    end
    sh_en[0] = 1;
    stream = '0; n = 0;
    for (int c = 0; c < 70; c++) begin
      if (sr_valid[0]) begin
        if (n < 48) stream[n] = sr_out1[0];
        n++;
      end
      tick();
      if (m_acc[0]) in_valid[0] = 0;
    end
    sh_en[0] = 0;
    chk("bp_drain_beats", n, 48);
    chk("bp_stream_lo", stream[31:0], {words[1], words[0]});
    chk("bp_stream_hi", stream[47:32], words[2]);

    // sparse sh_en, reset after the fifth shift
    offer(0, 16'h0020, 0, 4);
    tick();
    m_shifts[0] = 0;
    for (int c = 0; c < 60 && m_shifts[0] < 5; c++) begin
      sh_en[0] = (c % 3 == 2);
      tick();
    end
    sh_en[0] = 0;
    chk("irr_shift_count", m_shifts[0], 5);
    chk("irr_sr_out_bit5", sr_out1, 1);
    chk("irr_busy_before_rst", busy[0], 1);
    #2 rrst_n = 1'b0;
    #1;
    chk_reset_outputs("midword_reset");
    model_reset();
    tick();
    tick();
    chk("rst_no_done", word_done[0], 0);
    rrst_n = 1'b1;
    tick();
    chk_reset_outputs("after_reset");

    // randomized traffic on both instances
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 2; k++) begin
        in_valid[k] = ($urandom_range(0, 2) != 0);
        in_data[k]  = 16'($urandom);
        in_msb[k]   = $urandom_range(0, 1) == 1;
        sh_en[k]    = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Next-generation parallel-in/serial-out shifter for the serial interface receive-clock domain. Replaces the single-bit, load-strobe shift register.
- Adds a valid/ready word input, a one-entry holding buffer for gapless back-to-back words, and a configurable lane count (LANES bits per shift).
- Adds per-word MSB-first/LSB-first ordering, a beat counter with end-of-word pulse, and a serial-valid qualifier.
- Sits between the word source (FIFO read side) and the serial line driver.

Parameters:
- SSIZE, 16, word width in bits. Must be a multiple of LANES.
- LANES, 1, serial bits emitted per shift beat (1, 2, 4 or 8).
- BEATS (localparam), SSIZE/LANES, shift beats per word.
- CNT_W (localparam), $clog2(BEATS) (minimum 1), beat counter width.

Ports:
- rclk  in  1  clock, all state on rising edge.
- rrst_n  in  1  reset; asynchronous assert, active-low.
- in_data  in  SSIZE  parallel word.
- in_msb_first  in  1  ordering for this word; captured with in_data.
- in_valid  in  1  word offered.
- in_ready  out  1  holding buffer can accept a word.
- sh_en  in  1  beat strobe from the line timing; advances one beat.
- sr_out  out  LANES  current serial beat.
- sr_valid  out  1  sr_out carries word data.
- word_done  out  1  one-cycle pulse after the final beat of a word is consumed.
- busy  out  1  shift register active or holding buffer full.

Behaviour:
- Reset (async): shift reg, hold reg, hold_full, active, beat_cnt, mode bits and word_done all go to 0. After reset: in_ready=1, sr_valid=0, sr_out=0, busy=0.
- Accept rule: a word is accepted on a rising edge when in_valid && in_ready. in_ready = !hold_full, registered-derived, with no combinational path from in_valid or sh_en. On accept, hold_full is set and the data plus msb_first flag are captured.
- Hold→shift transfer occurs when hold_full and either:
  - (a) !active, or
  - (b) active && sh_en && beat_cnt==BEATS-1.
- On transfer: shift reg is loaded, mode is latched, beat_cnt=0, active=1, hold_full cleared. Same-edge accept into the hold is NOT possible because in_ready was 0.
- Latency: accept at edge N → hold full; load at edge N+1 → sr_valid=1 from N+1. First beat therefore appears 2 cycles after in_valid when idle.
- sr_out selection:
  - !active: all zeros.
  - LSB-first: sr_reg[LANES-1:0].
  - MSB-first: sr_reg[SSIZE-1 -: LANES].
- Shift on active && sh_en with beat_cnt<BEATS-1: LSB-first shifts right by LANES, MSB-first shifts left by LANES, zero fill; beat_cnt increments.
- Final beat (active && sh_en && beat_cnt==BEATS-1): word_done=1 for exactly the next cycle. Then either reload per (b) (active stays 1, gapless) or clear active (sr_valid=0 next cycle).
- sh_en while !active: ignored, no state change.
- sh_en low mid-word: the beat holds indefinitely; sr_out stays stable.
- sr_valid = active. busy = active || hold_full.
- in_msb_first is per-word; changing it mid-word has no effect on the word in flight.
- Reset asserted mid-word: the word is discarded immediately; no word_done pulse.

Decomposition:
- Shared package si_pkg holds the BEATS/CNT_W derivation function and the LANES legality check (elaboration-time $error if SSIZE % LANES != 0).
- One natural sub-module: si_hold_buf, a one-entry valid/ready holding register (data + mode flag, full flag, pop input). The top module owns the shifter, counter and done logic.

Test Plan:
- SSIZE=16, LANES=1, in_data=16'hA5C3, LSB-first, sh_en=1 continuously → sr_out sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 with sr_valid high for 16 cycles; word_done single pulse in the cycle after the 16th beat; in_ready back to 1 the cycle after load.
- Same word, in_msb_first=1 → sr_out 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
- LANES=4, in_data=16'h1234, LSB-first → sr_out nibbles 4,3,2,1. With MSB-first → 1,2,3,4.
- Back-to-back: 16'hFFFF then 16'h0000 offered early, sh_en=1 → 32 consecutive valid beats with no sr_valid gap; word_done pulses at beats 16 and 32 (+1 cycle).
- Backpressure: sh_en=0, in_valid held with three words → words 1 and 2 accepted (word 1 in shift reg, word 2 in hold), in_ready=0 while word 3 waits. sr_out shows word 1's beat 0 stably. Releasing sh_en drains all three in order.
- Irregular sh_en (1 every 3 cycles), with rrst_n pulsed low after beat 5 → exactly 5 shifts observed. On reset: sr_valid=0, sr_out=0, in_ready=1, busy=0 asynchronously, and no word_done pulse.
